chaos_engine_arbiter: RTL and testbench

//   Shares one chaotic-map keystream engine (tent50/logistic/tent chain) among NUM_REQ requesters.

---
 rtl/chaos_pkg.sv | 34 +++
 rtl/rr_pick.sv | 40 ++++
 rtl/chaos_engine_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_chaos_engine_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chaos_pkg.sv
`default_nettype none
// ============================================================================
// Package     : chaos_pkg
// Description : Shared types and constants for the chaotic-map keystream
//               engine arbiter: map-order (mode) codes, arbiter state
//               encoding and an index-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package chaos_pkg;

  // Map order selected by a requester and forwarded to the engine.
  typedef logic [1:0] mode_t;

  localparam mode_t MODE_TENT50   = 2'b00;
  localparam mode_t MODE_LOGISTIC = 2'b01;
  localparam mode_t MODE_TENT     = 2'b10;
  localparam mode_t MODE_CHAIN    = 2'b11;

  // Arbiter FSM encoding.
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_e;

  // Width of an index into n requesters; never narrower than 1 bit so that
  // a single-requester build still has a legal (constant-zero) pointer.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : chaos_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational rotate-priority encoder. Returns the first
//               asserted request at or after ptr_i, wrapping modulo NUM_REQ.
// Ports       : req_i  [NUM_REQ]  request vector
//               ptr_i  [IDX_W]    highest-priority index (< NUM_REQ)
//               idx_o  [IDX_W]    winning index (0 when any_o is low)
//               any_o             at least one request asserted
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  logic [IDX_W-1:0] w_cand;

  // Walk the requesters in priority order starting at the pointer; the first
  // hit wins and later candidates are masked by any_o.
  always_comb begin
    idx_o  = '0;
    any_o  = 1'b0;
    w_cand = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      w_cand = IDX_W'((int'(ptr_i) + k) % int'(NUM_REQ));
      if (!any_o && req_i[w_cand]) begin
        any_o = 1'b1;
        idx_o = w_cand;
      end
    end
  end

endmodule : rr_pick
`default_nettype wire

// File: rtl/chaos_engine_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : chaos_engine_arbiter
// Description : Shares one chaotic-map keystream engine among NUM_REQ
//               requesters. Round-robin pick, latch winner's seed/mode,
//               one-cycle engine start, wait for done, return the key.
//               FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
// Config      : CHAOS_ARB_TIMEOUT_EN - enables a WAIT-state watchdog that
//               answers with key 0 and rsp_err_o=1 after TIMEOUT_CYCLES.
// Ports       : clk, rst_n (async, active low)
//               req_i/req_seed_i/req_mode_i  requester side inputs
//               gnt_o, rsp_valid_o           one-hot single-cycle pulses
//               rsp_key_o, rsp_err_o         response data / timeout flag
//               eng_start_o/eng_seed_o/eng_mode_o, eng_done_i/eng_key_i
//                                            engine handshake
//               busy_o                       high whenever not IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module chaos_engine_arbiter
  import chaos_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 12,
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_seed_i,
  input  logic [NUM_REQ*2-1:0]          req_mode_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  output logic [NUM_REQ-1:0]            rsp_valid_o,
  output logic [DATA_WIDTH-1:0]         rsp_key_o,
  output logic                          rsp_err_o,
  output logic                          eng_start_o,
  output logic [DATA_WIDTH-1:0]         eng_seed_o,
  output logic [1:0]                    eng_mode_o,
  input  logic                          eng_done_i,
  input  logic [DATA_WIDTH-1:0]         eng_key_i,
  output logic                          busy_o
);

  localparam int unsigned IDX_W = idx_width(NUM_REQ);

  arb_state_e            state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [DATA_WIDTH-1:0] seed_q, seed_d;
  logic [DATA_WIDTH-1:0] key_q, key_d;
  mode_t                 mode_q, mode_d;
  logic                  err_q, err_d;

  logic [IDX_W-1:0]      w_pick_idx;
  logic                  w_pick_any;
  logic                  w_expired;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req_i (req_i),
    .ptr_i (rr_ptr_q),
    .idx_o (w_pick_idx),
    .any_o (w_pick_any)
  );

`ifdef CHAOS_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter reads 0 on the first WAIT cycle; it is cleared in every other state.
  always_comb begin
    cnt_d = '0;
    if (state_q == ARB_WAIT) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign w_expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
  assign w_expired        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB_IDLE;
      idx_q    <= '0;
      rr_ptr_q <= '0;
      seed_q   <= '0;
      key_q    <= '0;
      mode_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      rr_ptr_q <= rr_ptr_d;
      seed_q   <= seed_d;
      key_q    <= key_d;
      mode_q   <= mode_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rr_ptr_d    = rr_ptr_q;
    seed_d      = seed_q;
    key_d       = key_q;
    mode_d      = mode_q;
    err_d       = err_q;
    gnt_o       = '0;
    rsp_valid_o = '0;
    eng_start_o = 1'b0;
    rsp_err_o   = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (w_pick_any) begin
          idx_d   = w_pick_idx;
          // Constant-index mux keeps the seed/mode select free of
          // variable part-selects.
          for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (w_pick_idx == IDX_W'(i)) begin
              seed_d = req_seed_i[i*DATA_WIDTH +: DATA_WIDTH];
              mode_d = req_mode_i[i*2 +: 2];
            end
          end
          state_d = ARB_ISSUE;
        end
      end

      ARB_ISSUE: begin
        for (int i = 0; i < int'(NUM_REQ); i++) begin
          gnt_o[i] = (idx_q == IDX_W'(i));
        end
        eng_start_o = 1'b1;
        state_d     = ARB_WAIT;
      end

      ARB_WAIT: begin
        // A real completion beats an expiring watchdog in the same cycle.
        if (eng_done_i) begin
          key_d   = eng_key_i;
          err_d   = 1'b0;
          state_d = ARB_RESP;
        end else if (w_expired) begin
          key_d   = '0;
          err_d   = 1'b1;
          state_d = ARB_RESP;
        end
      end

      ARB_RESP: begin
        for (int i = 0; i < int'(NUM_REQ); i++) begin
          rsp_valid_o[i] = (idx_q == IDX_W'(i));
        end
        rsp_err_o = err_q;
        rr_ptr_d  = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + IDX_W'(1);
        state_d   = ARB_IDLE;
      end

      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  assign rsp_key_o  = key_q;
  assign eng_seed_o = seed_q;
  assign eng_mode_o = mode_q;
  assign busy_o     = (state_q != ARB_IDLE);

endmodule : chaos_engine_arbiter
`default_nettype wire

// File: tb/tb_chaos_engine_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_chaos_engine_arbiter
// Description : Self-checking bench for chaos_engine_arbiter. A timestamp
//               based transaction model predicts every output each cycle;
//               directed sequences pin literal values; a randomized phase
//               drives requesters and an engine responder.
// Config      : CHAOS_ARB_TIMEOUT_EN enables the watchdog sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_chaos_engine_arbiter;

  localparam int DW = 12;
  localparam int N  = 4;
  localparam int TO = 8;
`ifdef CHAOS_ARB_TIMEOUT_EN
  localparam int T1_LAT = 7;
`else
  localparam int T1_LAT = 10;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*DW-1:0] req_seed = '0;
  logic [N*2-1:0]  req_mode = '0;
  logic [N-1:0]    gnt, rsp_valid;
  logic [DW-1:0]   rsp_key, eng_seed;
  logic [DW-1:0]   eng_key = '0;
  logic            rsp_err, eng_start, busy;
  logic            eng_done = 1'b0;
  logic [1:0]      eng_mode;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  chaos_engine_arbiter #(
    .DATA_WIDTH     (DW),
    .NUM_REQ        (N),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req),
    .req_seed_i  (req_seed),
    .req_mode_i  (req_mode),
    .gnt_o       (gnt),
    .rsp_valid_o (rsp_valid),
    .rsp_key_o   (rsp_key),
    .rsp_err_o   (rsp_err),
    .eng_start_o (eng_start),
    .eng_seed_o  (eng_seed),
    .eng_mode_o  (eng_mode),
    .eng_done_i  (eng_done),
    .eng_key_i   (eng_key),
    .busy_o      (busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction model ----------------
  // owner = requester currently being served (-1 none); gcyc = cycle in which
  // its grant shows; dcyc = cycle in which the engine answered (or timed out).
  int            cyc = 0;
  int            m_ptr = 0;
  int            m_owner = -1;
  int            m_gcyc = 0;
  int            m_dcyc = -1;
  int            m_w;
  logic [DW-1:0] m_seed = '0;
  logic [DW-1:0] m_key = '0;
  logic [1:0]    m_mode = '0;
  logic          m_err = 1'b0;

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0; m_ptr = 0; m_owner = -1; m_gcyc = 0; m_dcyc = -1;
      m_seed = '0; m_key = '0; m_mode = '0; m_err = 1'b0;
    end else begin
      if (m_owner < 0) begin
        m_w = pick(req, m_ptr);
        if (m_w >= 0) begin
          m_owner = m_w;
          m_gcyc  = cyc + 1;
          m_dcyc  = -1;
          m_seed  = req_seed[m_w*DW +: DW];
          m_mode  = req_mode[m_w*2 +: 2];
        end
      end else if (m_dcyc < 0 && cyc > m_gcyc) begin
        if (eng_done) begin
          m_dcyc = cyc; m_key = eng_key; m_err = 1'b0;
        end
`ifdef CHAOS_ARB_TIMEOUT_EN
        else if (cyc - m_gcyc - 1 == TO) begin
          m_dcyc = cyc; m_key = '0; m_err = 1'b1;
        end
`endif
      end else if (m_dcyc >= 0 && cyc == m_dcyc + 1) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end
      cyc++;
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [N-1:0] e_gnt, e_rsp;
  always @(negedge clk) begin
    e_gnt = '0;
    e_rsp = '0;
    if (m_owner >= 0 && cyc == m_gcyc) e_gnt[m_owner] = 1'b1;
    if (m_owner >= 0 && m_dcyc >= 0 && cyc == m_dcyc + 1) e_rsp[m_owner] = 1'b1;
    chk("m_gnt", gnt, e_gnt);
    chk("m_eng_start", eng_start, |e_gnt);
    chk("m_rsp_valid", rsp_valid, e_rsp);
    chk("m_rsp_err", rsp_err, (|e_rsp) & m_err);
    chk("m_rsp_key", rsp_key, m_key);
    chk("m_eng_seed", eng_seed, m_seed);
    chk("m_eng_mode", eng_mode, m_mode);
    chk("m_busy", busy, m_owner >= 0);
  end

  // ---------------- directed helpers ----------------
  task automatic serve(input string nm, input logic [N-1:0] exp_g, input int lat,
                       input logic [DW-1:0] k, output int wait_n);
    int n;
    n = 0;
    while (gnt == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    wait_n = n;
    chk({nm, "_gnt"}, gnt, exp_g);
    req = req & ~gnt;
    repeat (lat) @(negedge clk);
    eng_done = 1'b1;
    eng_key  = k;
    @(negedge clk);
    eng_done = 1'b0;
    chk({nm, "_rsp_valid"}, rsp_valid, exp_g);
    chk({nm, "_rsp_key"}, rsp_key, k);
  endtask

  logic [N-1:0] t2_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  int eng_cnt = 0;

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("reset_gnt", gnt, 0);
    chk("reset_busy", busy, 0);
    chk("reset_key", rsp_key, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // All four requesters held: grants rotate 0,1,2,3,0.
    req = '1;
    for (int j = 0; j < 5; j++) begin
      serve("t2", t2_exp[j], 1 + j, DW'(12'h100 + j), n);
      req = (j < 4) ? '1 : '0;
    end

    // Single requester 2, logistic map.
    @(negedge clk);
    req_seed[2*DW +: DW] = 12'h5A3;
    req_mode[2*2 +: 2]   = 2'b01;
    req = 4'b0100;
    serve("t1", 4'b0100, T1_LAT, 12'hABC, n);
    chk("t1_latency", n, 1);
    chk("t1_eng_seed", eng_seed, 12'h5A3);
    chk("t1_eng_mode", eng_mode, 2'b01);

    // Pointer now 3: 1011 -> 3; then 0100 -> 2; then 0001 wraps -> 0; then 1111 -> 1.
    req = 4'b1011;
    serve("ptr3", 4'b1000, 2, 12'h111, n);
    req = 4'b0100;
    serve("ptr0", 4'b0100, 2, 12'h222, n);
    req = 4'b0001;
    serve("t3_wrap", 4'b0001, 3, 12'h333, n);
    req = 4'b1111;
    serve("t3_ptr1", 4'b0010, 1, 12'h444, n);
    req = '0;

    // Spurious done in IDLE and ISSUE.
    @(negedge clk);
    @(negedge clk);
    eng_done = 1'b1;
    @(negedge clk);
    chk("t5_idle_busy", busy, 0);
    req = 4'b0100;
    eng_done = 1'b0;
    @(negedge clk);
    chk("t5_gnt", gnt, 4'b0100);
    eng_done = 1'b1;
    req = '0;
    @(negedge clk);
    eng_done = 1'b0;
    chk("t5_wait_busy", busy, 1);
    repeat (3) begin
      @(negedge clk);
      chk("t5_no_rsp", rsp_valid, 0);
    end
    eng_done = 1'b1;
    eng_key  = 12'h5C5;
    @(negedge clk);
    eng_done = 1'b0;
    chk("t5_rsp", rsp_valid, 4'b0100);

    // Reset in the middle of WAIT.
    @(negedge clk);
    req = 4'b0010;
    @(negedge clk);
    chk("t4_gnt", gnt, 4'b0010);
    req = '0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_busy", busy, 0);
    chk("t4_key", rsp_key, 0);
    chk("t4_seed", eng_seed, 0);
    chk("t4_gnt0", gnt, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t4_no_rsp", rsp_valid, 0);
    end
    req = 4'b1111;
    serve("t4_restart", 4'b0001, 2, 12'h777, n);
    req = '0;

`ifdef CHAOS_ARB_TIMEOUT_EN
    // Engine never answers: timeout response.
    @(negedge clk);
    req = 4'b0001;
    @(negedge clk);
    chk("t6_gnt", gnt, 4'b0001);
    req = '0;
    n = 0;
    while (rsp_valid == '0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("t6_to_cycles", n, TO + 2);
    chk("t6_to_err", rsp_err, 1);
    chk("t6_to_key", rsp_key, 0);
    // Done exactly in the expiry cycle wins.
    @(negedge clk);
    req = 4'b0010;
    @(negedge clk);
    chk("t6_gnt2", gnt, 4'b0010);
    req = '0;
    repeat (TO + 1) @(negedge clk);
    eng_done = 1'b1;
    eng_key  = 12'h123;
    @(negedge clk);
    eng_done = 1'b0;
    chk("t6_edge_rsp", rsp_valid, 4'b0010);
    chk("t6_edge_err", rsp_err, 0);
    chk("t6_edge_key", rsp_key, 12'h123);
`endif

    // Randomized traffic against the model.
    req = '0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (gnt[i]) begin
          req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(3) == 0) begin
          req[i]               = 1'b1;
          req_seed[i*DW +: DW] = DW'($urandom);
          req_mode[i*2 +: 2]   = 2'($urandom);
        end
      end
      eng_done = 1'b0;
      if (eng_start) begin
        eng_cnt = $urandom_range(1, 12);
      end else if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) eng_done = 1'b1;
      end else if ($urandom_range(15) == 0) begin
        eng_done = 1'b1;
      end
      eng_key = DW'($urandom);
    end
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "bench timeout");
  end

endmodule : tb_chaos_engine_arbiter
`default_nettype wire
